// File: rtl/rr_load_pkg.sv
// Shared types and constants for the round-robin load scheduler and related arbiters.
package rr_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic [1:0] PE_LOAD = 2'b11;
    localparam logic [1:0] PE_HOLD = 2'b00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default first, so no path through this block can infer a latch.
        idx_o   = '0;
        valid_o = |req_i;
        // Scan from the farthest offset to the nearest, so the requester closest to ptr is written last.
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) cand = cand - N;
            if (req_i[cand]) idx_o = IW'(cand);
        end
        onehot_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/rr_load_sched.sv
// Round-robin scheduler that owns the PE/D inputs of one shared parallel-load register.
// Optional build macro RR_LOAD_SCHED_LOCK_EN adds a per-requester lock input that pins the pointer.
module rr_load_sched
    import rr_load_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           r,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
`ifdef RR_LOAD_SCHED_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [1:0]     pe,
    output logic [W-1:0]   d,
    output logic [W-1:0]   shadow,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q,  state_d;
    logic [IW-1:0] ptr_q,    ptr_d;
    logic [IW-1:0] win_q,    win_d;
    logic [N-1:0]  gnt_q,    gnt_d;
    logic [N-1:0]  ack_q,    ack_d;
    logic [1:0]    pe_q,     pe_d;
    logic [W-1:0]  data_q,   data_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic          busy_q,   busy_d;

    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [IW-1:0] ptr_adv;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    assign ptr_adv = (int'(win_q) == N - 1) ? '0 : win_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = '0;
        ack_d    = '0;
        pe_d     = PE_HOLD;
        data_d   = data_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LOAD;
                    win_d   = pick_idx;
                    gnt_d   = pick_oh;
                    pe_d    = PE_LOAD;
                    data_d  = din[int'(pick_idx)*W +: W];
                end
            end
            LOAD: begin
                state_d  = ACK;
                ack_d    = gnt_q;
                shadow_d = data_q;
                ptr_d    = ptr_adv;
`ifdef RR_LOAD_SCHED_LOCK_EN
                // A locked winner keeps the pointer on itself so it wins again while it requests.
                if (lock[win_q]) ptr_d = win_q;
`endif
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            pe_q     <= PE_HOLD;
            data_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, in any order.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            pe_q     <= pe_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign pe     = pe_q;
    assign d      = data_q;
    assign shadow = shadow_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rr_load_sched.sv
// Bench for rr_load_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_rr_load_sched;

    localparam int N = 4;
    localparam int W = 4;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic [1:0]   pe;
        logic [W-1:0] d;
        logic [W-1:0] shadow;
        logic         busy;
        int           win;
    } rec_t;

    logic           clk = 1'b0;
    logic           r;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
`ifdef RR_LOAD_SCHED_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [1:0]     pe;
    logic [W-1:0]   d;
    logic [W-1:0]   shadow;
    logic           busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_ptr = 0;
    rec_t cur;
    rec_t exp_q[$];
    logic [N-1:0] got[$];
    logic [W-1:0] got_d[$];
    int           got_cyc[$];

    always #5 clk = ~clk;

    rr_load_sched #(.N(N), .W(W)) dut (
        .clk    (clk),
        .r      (r),
        .req    (req),
        .din    (din),
`ifdef RR_LOAD_SCHED_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .ack    (ack),
        .pe     (pe),
        .d      (d),
        .shadow (shadow),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic rec_t mk(logic [N-1:0] g, logic [N-1:0] a, logic [1:0] p,
                                logic [W-1:0] dv, logic [W-1:0] sh, logic b, int w);
        rec_t x;
        x.gnt = g; x.ack = a; x.pe = p; x.d = dv; x.shadow = sh; x.busy = b; x.win = w;
        return x;
    endfunction

    // Transaction model: an accepted request expands into its load, ack and recovery cycles.
    task automatic model_edge();
        int           w;
        logic [W-1:0] word;
        if (r) begin
            exp_q.delete();
            m_ptr = 0;
            cur   = mk('0, '0, 2'b00, '0, '0, 1'b0, 0);
            return;
        end
        if (exp_q.size() == 0 && req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            word = din[w*W +: W];
            exp_q.push_back(mk(N'(1) << w, '0, 2'b11, word, cur.shadow, 1'b1, w));
            exp_q.push_back(mk('0, N'(1) << w, 2'b00, word, word, 1'b1, w));
            exp_q.push_back(mk('0, '0, 2'b00, word, word, 1'b0, w));
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.ack != '0) begin
                m_ptr = (cur.win + 1) % N;
`ifdef RR_LOAD_SCHED_LOCK_EN
                if (lock[cur.win]) m_ptr = cur.win;
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("gnt",    32'(gnt),    32'(cur.gnt));
        check("ack",    32'(ack),    32'(cur.ack));
        check("pe",     32'(pe),     32'(cur.pe));
        check("d",      32'(d),      32'(cur.d));
        check("shadow", 32'(shadow), 32'(cur.shadow));
        check("busy",   32'(busy),   32'(cur.busy));
    endtask

    task automatic collect(input int max_cyc, input int want);
        for (int c = 0; c < max_cyc && got.size() < want; c++) begin
            step();
            if (gnt != '0) begin
                got.push_back(gnt);
                got_d.push_back(d);
                got_cyc.push_back(cyc);
            end
        end
        check("grant_count", 32'(got.size() >= want), 32'd1);
    endtask

    function automatic logic [31:0] got_at(int i);
        return (i < got.size()) ? 32'(got[i]) : 32'hDEAD;
    endfunction

    initial begin
        r   = 1'b1;
        req = 4'b1111;
        din = '0;
`ifdef RR_LOAD_SCHED_LOCK_EN
        lock = '0;
`endif
        cur = mk('0, '0, 2'b00, '0, '0, 1'b0, 0);

        // Reset held for two cycles with every requester asking.
        step();
        step();
        check("rst_gnt",    32'(gnt),    32'h0);
        check("rst_ack",    32'(ack),    32'h0);
        check("rst_pe",     32'(pe),     32'h0);
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_shadow", 32'(shadow), 32'h0);

        // Single request from requester 2.
        r = 1'b0; req = 4'b0100; din = 16'h0A00;
        step();
        check("single_gnt", 32'(gnt), 32'b0100);
        check("single_pe",  32'(pe),  32'b11);
        check("single_d",   32'(d),   32'hA);
        step();
        check("single_ack",    32'(ack),    32'b0100);
        check("single_shadow", 32'(shadow), 32'hA);
        req = '0;
        step();

        // Pointer now sits at 3: requesters 0 and 1 win in that order.
        req = 4'b0011; din = 16'h7777;
        got.delete(); got_d.delete(); got_cyc.delete();
        collect(12, 2);
        check("wrap_0", got_at(0), 32'b0001);
        check("wrap_1", got_at(1), 32'b0010);

        // All four requesting continuously from a fresh pointer.
        r = 1'b1; step(); r = 1'b0;
        req = 4'b1111; din = 16'h4321;
        got.delete(); got_d.delete(); got_cyc.delete();
        collect(20, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_gnt%0d", i), got_at(i), 32'(N'(1) << (i % N)));
            if (i < got_d.size()) check($sformatf("rr_d%0d", i), 32'(got_d[i]), 32'((i % N) + 1));
            if (i > 0 && i < got_cyc.size())
                check($sformatf("rr_gap%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);
        end

        // Reset while requester 1 is in its load cycle.
        r = 1'b1; step(); r = 1'b0;
        req = 4'b0010; din = 16'h0050;
        step();
        check("midrst_gnt", 32'(gnt), 32'b0010);
        check("midrst_d",   32'(d),   32'h5);
        r = 1'b1;
        step();
        check("midrst_ack",    32'(ack),    32'h0);
        check("midrst_shadow", 32'(shadow), 32'h0);
        r = 1'b0; req = 4'b0011;
        step();
        check("midrst_ptr0", 32'(gnt), 32'b0001);
        check("midrst_ack2", 32'(ack), 32'h0);
        req = '0;
        step(); step(); step();

`ifdef RR_LOAD_SCHED_LOCK_EN
        // Locked requester 0 wins repeatedly; releasing it during its load passes the turn on.
        r = 1'b1; step(); r = 1'b0;
        req = 4'b0011; lock = 4'b0001; din = 16'h00C3;
        got.delete(); got_d.delete(); got_cyc.delete();
        for (int c = 0; c < 14 && got.size() < 3; c++) begin
            step();
            if (gnt != '0) begin
                got.push_back(gnt);
                if (got.size() == 3) lock = '0;
            end
        end
        collect(6, 4);
        check("lock_0", got_at(0), 32'b0001);
        check("lock_1", got_at(1), 32'b0001);
        check("lock_2", got_at(2), 32'b0001);
        check("lock_3", got_at(3), 32'b0010);
`endif

        // Random traffic, including drops during a load and occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            din = (N*W)'($urandom);
`ifdef RR_LOAD_SCHED_LOCK_EN
            lock = N'($urandom);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
